// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : 640x480@60 vertical timing constants, region state type and
//                line-sequence helper. Shared by the vertical timing stage and
//                the horizontal timing stage.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

  localparam int LINE_W   = 10;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // First line of each region, sized to the line-count bus.
  localparam logic [LINE_W-1:0] LINE_ACT_START = '0;
  localparam logic [LINE_W-1:0] LINE_FP_START  = LINE_W'(V_ACTIVE);
  localparam logic [LINE_W-1:0] LINE_SYN_START = LINE_W'(V_ACTIVE + V_FRONT);
  localparam logic [LINE_W-1:0] LINE_BP_START  = LINE_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [LINE_W-1:0] LINE_TOTAL     = LINE_W'(V_TOTAL);
  localparam logic [LINE_W-1:0] LINE_LAST      = LINE_W'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    V_ACT = 2'd0,
    V_FP  = 2'd1,
    V_SYN = 2'd2,
    V_BP  = 2'd3
  } vstate_t;

  // Line that must follow 'prev' in an unbroken frame sequence.
  function automatic logic [LINE_W-1:0] next_line(input logic [LINE_W-1:0] prev);
    return (prev == LINE_LAST) ? LINE_ACT_START : prev + LINE_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_vtiming_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_vtiming_fsm_if
//  Description : Line-counter input and vertical-timing output bundle.
//  Signals     : i_line_en     line-advance strobe (one cycle)
//                i_line_cnt    current line number
//                i_err_clr     clears the sticky sync error
//                o_vsync       vertical sync at VSYNC_POL level in sync region
//                o_vactive     visible-line flag
//                o_frame_start one-cycle pulse on entering line 0
//                o_frame_cnt   completed-frame counter
//                o_locked      a valid line has been seen since reset
//                o_sync_err    sticky line-sequence break flag
//  Modports    : master drives i_*, slave (the timing stage) drives o_*
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_vtiming_fsm_if #(
  parameter int FRAME_W = 8
);
  import vga_timing_pkg::*;

  logic                i_line_en;
  logic [LINE_W-1:0]   i_line_cnt;
  logic                i_err_clr;
  logic                o_vsync;
  logic                o_vactive;
  logic                o_frame_start;
  logic [FRAME_W-1:0]  o_frame_cnt;
  logic                o_locked;
  logic                o_sync_err;

  modport master (
    output i_line_en, i_line_cnt, i_err_clr,
    input  o_vsync, o_vactive, o_frame_start, o_frame_cnt, o_locked, o_sync_err
  );

  modport slave (
    input  i_line_en, i_line_cnt, i_err_clr,
    output o_vsync, o_vactive, o_frame_start, o_frame_cnt, o_locked, o_sync_err
  );

endinterface
`default_nettype wire

// File: rtl/vga_vregion_decode.sv
`default_nettype none
// ============================================================================
//  Module      : vga_vregion_decode
//  Description : Combinational map from a line number to its vertical region,
//                plus a flag saying whether the line number is in range.
//                Used for both initial lock and resync so the region
//                boundaries are defined in one place.
//  Ports       : i_line   line number
//                o_region region containing i_line (don't-care when invalid)
//                o_valid  i_line < V_TOTAL
//  Revision    : 1.0  initial release
// ============================================================================
module vga_vregion_decode
  import vga_timing_pkg::*;
(
  input  wire logic [LINE_W-1:0] i_line,
  output vstate_t                o_region,
  output logic                   o_valid
);

  always_comb begin
    o_valid = (i_line < LINE_TOTAL);
    if (i_line < LINE_FP_START) begin
      o_region = V_ACT;
    end else if (i_line < LINE_SYN_START) begin
      o_region = V_FP;
    end else if (i_line < LINE_BP_START) begin
      o_region = V_SYN;
    end else begin
      o_region = V_BP;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_vtiming_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : vga_vtiming_fsm
//  Description : Vertical timing stage for 640x480@60. Tracks the vertical
//                region from the line counter, produces registered VSYNC,
//                VActive, FrameStart and FrameCnt, and flags line sequences
//                that break lock (resyncing to the observed line).
//  Ports       : i_clk  clock, rising edge
//                i_rst  synchronous active-high reset
//                bus    vga_vtiming_fsm_if.slave (line input, timing outputs)
//  Revision    : 1.0  initial release
// ============================================================================
module vga_vtiming_fsm
  import vga_timing_pkg::*;
#(
  parameter logic VSYNC_POL = 1'b0,
  parameter int   FRAME_W   = 8
) (
  input wire logic          i_clk,
  input wire logic          i_rst,
  vga_vtiming_fsm_if.slave  bus
);

  vstate_t             r_state;
  vstate_t             w_state_nxt;
  logic [LINE_W-1:0]   r_prev_line;
  logic [LINE_W-1:0]   w_prev_nxt;
  logic                r_locked;
  logic                w_locked_nxt;
  logic                r_sync_err;
  logic                w_sync_err_nxt;
  logic                w_err_det;
  logic [FRAME_W-1:0]  r_frame_cnt;
  logic [FRAME_W-1:0]  w_frame_cnt_nxt;
  logic                r_frame_start;
  logic                w_frame_start_nxt;
  logic                r_vsync;
  logic                r_vactive;

  vstate_t             w_region;
  logic                w_valid;
  logic [LINE_W-1:0]   w_expected;

  vga_vregion_decode u_decode (
    .i_line   (bus.i_line_cnt),
    .o_region (w_region),
    .o_valid  (w_valid)
  );

  assign w_expected = next_line(r_prev_line);

  // Next-state / next-output logic. Out-of-range line numbers (e.g. the
  // counter's transient 525) fall through and leave everything untouched.
  always_comb begin
    w_state_nxt       = r_state;
    w_prev_nxt        = r_prev_line;
    w_locked_nxt      = r_locked;
    w_frame_cnt_nxt   = r_frame_cnt;
    w_frame_start_nxt = 1'b0;
    w_err_det         = 1'b0;

    if (bus.i_line_en && w_valid) begin
      w_prev_nxt   = bus.i_line_cnt;
      w_locked_nxt = 1'b1;
      if (!r_locked) begin
        // First valid sample: adopt its region, no frame event yet.
        w_state_nxt = w_region;
      end else begin
        if (bus.i_line_cnt == w_expected) begin
          case (bus.i_line_cnt)
            LINE_ACT_START: w_state_nxt = V_ACT;
            LINE_FP_START:  w_state_nxt = V_FP;
            LINE_SYN_START: w_state_nxt = V_SYN;
            LINE_BP_START:  w_state_nxt = V_BP;
            default:        w_state_nxt = r_state;
          endcase
        end else begin
          w_err_det   = 1'b1;
          w_state_nxt = w_region;
        end
        // Line 0 starts a frame whether reached in sequence or by resync.
        if (bus.i_line_cnt == LINE_ACT_START) begin
          w_frame_start_nxt = 1'b1;
          w_frame_cnt_nxt   = r_frame_cnt + FRAME_W'(1);
        end
      end
    end

    // A fresh error takes priority over a clear in the same cycle.
    if (w_err_det) begin
      w_sync_err_nxt = 1'b1;
    end else if (bus.i_err_clr) begin
      w_sync_err_nxt = 1'b0;
    end else begin
      w_sync_err_nxt = r_sync_err;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= V_BP;
      r_prev_line   <= LINE_LAST;
      r_locked      <= 1'b0;
      r_sync_err    <= 1'b0;
      r_frame_cnt   <= '0;
      r_frame_start <= 1'b0;
      r_vsync       <= ~VSYNC_POL;
      r_vactive     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_prev_line   <= w_prev_nxt;
      r_locked      <= w_locked_nxt;
      r_sync_err    <= w_sync_err_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_frame_start <= w_frame_start_nxt;
      // Decoded from the next state so outputs track the state register.
      r_vsync       <= (w_state_nxt == V_SYN) ? VSYNC_POL : ~VSYNC_POL;
      r_vactive     <= (w_state_nxt == V_ACT);
    end
  end

  assign bus.o_vsync       = r_vsync;
  assign bus.o_vactive     = r_vactive;
  assign bus.o_frame_start = r_frame_start;
  assign bus.o_frame_cnt   = r_frame_cnt;
  assign bus.o_locked      = r_locked;
  assign bus.o_sync_err    = r_sync_err;

endmodule
`default_nettype wire
